pulse_period_meter: RTL and testbench
=====================================

Name: pulse_period_meter

Overview:
- Receive-side counterpart to the team's clock/pulse divider.
- Takes an asynchronous pulse train (e.g. a divider's q output), synchronises it to clk, and measures each period and high time in clk cycles.
- Publishes each result with a one-cycle valid strobe. Used to check divider ratios in-system and to qualify external pulse sources.

Parameters:
- CNT_W, 16: width of the period and high-time counters and outputs.
- SYNC_STAGES, 2: flip-flop stages in the pulse_in synchroniser; must be 2 or more.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  measurement enable; low forces IDLE.
- pulse_in  input  1  asynchronous pulse train to measure.
- period  output  CNT_W  clk cycles between last two rising edges of pulse_in.
- high_time  output  CNT_W  clk cycles pulse_in was high within that period.
- valid  output  1  one-cycle strobe; period/high_time updated this cycle.
- locked  output  1  at least one valid measurement since the last enable or overflow.
- overflow  output  1  sticky: period exceeded 2^CNT_W-1; cleared on next valid.

Behaviour:
- Reset (reset=0, asynchronous) clears immediately:
  - synchroniser flops, edge register, counters, state=IDLE;
  - outputs period=0, high_time=0, valid=0, locked=0, overflow=0.
- Synchroniser and edges:
  - pulse_in passes through SYNC_STAGES flops; s is the last stage, s_d is s delayed by one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Latency from pulse_in to rise/fall is SYNC_STAGES+1 cycles. Both edges see the same delay, so measurements are unaffected.
- States: IDLE, WAIT_EDGE, MEASURE.
  - IDLE: counters held at 0, valid=0. enable=1 -> WAIT_EDGE.
  - WAIT_EDGE: on rise -> MEASURE, cnt<=1, hcnt<=1. No output is produced for this first edge.
  - MEASURE, no rise: cnt<=cnt+1. hcnt<=hcnt+1 while s=1. On fall, hi_cap<=hcnt.
  - MEASURE, rise:
    - period<=cnt, high_time<=hi_cap, valid<=1 next cycle (registered with data);
    - locked<=1, overflow<=0;
    - cnt<=1, hcnt<=1; stay in MEASURE.
  - MEASURE, cnt = 2^CNT_W-1 with no rise:
    - overflow<=1, locked<=0, cnt<=0, no valid;
    - -> WAIT_EDGE; the next rise restarts the measurement.
  - MEASURE, cnt = max and rise in the same cycle: the rise wins. period=max, valid=1, no overflow.
  - hcnt saturates at 2^CNT_W-1 and never wraps.
- enable:
  - enable=0 in any state -> IDLE next cycle; locked<=0, valid<=0, counters cleared.
  - period, high_time and overflow retain their values.
  - Re-enable starts in WAIT_EDGE; the first period after re-enable is never reported.
- Arithmetic:
  - All counts are unsigned CNT_W bits; no wrap-around is permitted.
  - Minimum measurable period is 2: pulse_in toggling every clk gives period=2, high_time=1.
  - A rise with no fall since the previous rise (signal stuck high between syncs, impossible after sync) reports the hi_cap from the previous cycle.
- valid is high for exactly one cycle per measured period; never high in IDLE or WAIT_EDGE.
- Reset asserted mid-measurement aborts the measurement with no valid. After release the block is in IDLE and needs enable plus two rising edges before the next valid.

Test Plan:
- reset low 20ns then high, enable=1, pulse_in period 10 clk with high 5 clk for 5 periods -> valid pulses every 10 cycles from the 2nd rising edge on; period=10, high_time=5, locked=1, overflow=0.
- pulse_in toggles every clk (divide-by-2) -> period=2, high_time=1 on every valid; no missed strobes.
- CNT_W=4, pulse_in held low 20 cycles after lock -> overflow=1, locked=0, no valid. Resume period 6, high 2 -> first valid after the 2nd new edge with period=6, high_time=2, overflow=0.
- Duty change from period 8/high 2 to period 8/high 6 -> consecutive valids report high_time=2 then high_time=6, period=8 throughout.
- enable dropped mid-period, re-asserted 3 cycles later -> locked=0 immediately after, no valid for the interrupted period, period holds old value until the 2nd edge after re-enable.
- reset pulsed low asynchronously between clk edges mid-measurement -> all outputs 0 before the next clk edge; no spurious valid after release.

Source files
------------

// File: rtl/pulse_period_meter.sv
// Measures the period and high time of an asynchronous pulse train in clk cycles.
// Each result is published with a one-cycle valid strobe; long gaps flag overflow and drop lock.
module pulse_period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             overflow
);

  // state     | meaning
  // IDLE      | disabled; counters held at zero
  // WAIT_EDGE | armed; the next rise starts a measurement but reports nothing
  // MEASURE   | counting between rises; each rise publishes the previous period
  typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s, s_d, rise, fall;
  logic [CNT_W-1:0]       cnt, hcnt, hi_cap;

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pulse_in};
      s_d  <= s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (enable) state_nxt = WAIT_EDGE;
      WAIT_EDGE: if (rise) state_nxt = MEASURE;
      MEASURE:   if (!rise && cnt == CNT_MAX) state_nxt = WAIT_EDGE;
      default:   state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      hcnt      <= '0;
      hi_cap    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      overflow  <= 1'b0;
    end else if (!enable) begin
      // published results and the overflow flag survive a disable
      cnt    <= '0;
      hcnt   <= '0;
      hi_cap <= '0;
      valid  <= 1'b0;
      locked <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt  <= '0;
          hcnt <= '0;
        end
        WAIT_EDGE: begin
          if (rise) begin
            cnt  <= CNT_ONE;
            hcnt <= CNT_ONE;
          end
        end
        MEASURE: begin
          if (fall) hi_cap <= hcnt;
          if (rise) begin
            period    <= cnt;
            high_time <= hi_cap;
            valid     <= 1'b1;
            locked    <= 1'b1;
            overflow  <= 1'b0;
            cnt       <= CNT_ONE;
            hcnt      <= CNT_ONE;
          end else if (cnt == CNT_MAX) begin
            overflow <= 1'b1;
            locked   <= 1'b0;
            cnt      <= '0;
            hcnt     <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
            if (s && hcnt != CNT_MAX) hcnt <= hcnt + CNT_ONE;
          end
        end
        default: begin
          cnt  <= '0;
          hcnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: a 16-bit instance for the main behaviour and a
// 4-bit instance sharing pulse_in for the overflow path.
module tb_pulse_period_meter;

  logic        clk = 1'b0;
  logic        reset, enable, enable_s, pulse_in;
  logic [15:0] period_b, high_b;
  logic        valid_b, locked_b, overflow_b;
  logic [3:0]  period_s, high_s;
  logic        valid_s, locked_s, overflow_s;

  int tests = 0;
  int fails = 0;

  logic [31:0] q_big[$];
  logic [7:0]  q_small[$];

  always #5 clk = ~clk;

  pulse_period_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut_big (
    .clk(clk), .reset(reset), .enable(enable), .pulse_in(pulse_in),
    .period(period_b), .high_time(high_b), .valid(valid_b),
    .locked(locked_b), .overflow(overflow_b)
  );

  pulse_period_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut_small (
    .clk(clk), .reset(reset), .enable(enable_s), .pulse_in(pulse_in),
    .period(period_s), .high_time(high_s), .valid(valid_s),
    .locked(locked_s), .overflow(overflow_s)
  );

  // every strobe is logged, so a stuck or doubled valid shows up as an extra entry
  always @(negedge clk) begin
    if (valid_b) q_big.push_back({period_b, high_b});
    if (valid_s) q_small.push_back({period_s, high_s});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pop_big(input string tag, input int p, input int h);
    logic [31:0] v;
    logic [31:0] e;
    v = (q_big.size() > 0) ? q_big.pop_front() : 32'hDEAD_BEEF;
    e = {p[15:0], h[15:0]};
    chk(tag, v, e);
  endtask

  task automatic pop_small(input string tag, input int p, input int h);
    logic [31:0] v;
    logic [31:0] e;
    v = (q_small.size() > 0) ? {24'h0, q_small.pop_front()} : 32'hDEAD_BEEF;
    e = {24'h0, p[3:0], h[3:0]};
    chk(tag, v, e);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic per(input int p, input int h);
    pulse_in = 1'b1;
    cycles(h);
    pulse_in = 1'b0;
    cycles(p - h);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " period"}, 32'(period_b), 32'd0);
    chk({tag, " high"}, 32'(high_b), 32'd0);
    chk({tag, " valid"}, 32'(valid_b), 32'd0);
    chk({tag, " locked"}, 32'(locked_b), 32'd0);
    chk({tag, " overflow"}, 32'(overflow_b), 32'd0);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; enable_s = 1'b0; pulse_in = 1'b0;
    #12;
    chk_zero("in_reset");
    #8 reset = 1'b1;
    tick();
    chk_zero("after_reset");

    // 10/5 for five periods: four strobes
    enable = 1'b1;
    cycles(2);
    repeat (5) per(10, 5);
    chk("b10 count", 32'(q_big.size()), 32'd4);
    repeat (4) pop_big("b10 entry", 10, 5);
    chk("b10 locked", 32'(locked_b), 32'd1);
    chk("b10 overflow", 32'(overflow_b), 32'd0);

    // divide-by-2 on both instances, then 20 low cycles to overflow the 4-bit one
    enable_s = 1'b1;
    repeat (10) per(2, 1);
    cycles(20);
    chk("tog count", 32'(q_big.size()), 32'd10);
    pop_big("tog boundary", 10, 5);
    repeat (9) pop_big("tog entry", 2, 1);
    chk("tog small count", 32'(q_small.size()), 32'd9);
    repeat (9) pop_small("tog small entry", 2, 1);
    chk("ovf small overflow", 32'(overflow_s), 32'd1);
    chk("ovf small locked", 32'(locked_s), 32'd0);
    chk("ovf big overflow", 32'(overflow_b), 32'd0);
    chk("ovf big locked", 32'(locked_b), 32'd1);

    // resume 6/2: small reports from the second new rise
    repeat (3) per(6, 2);
    chk("res count", 32'(q_big.size()), 32'd3);
    pop_big("res gap", 22, 1);
    repeat (2) pop_big("res entry", 6, 2);
    chk("res small count", 32'(q_small.size()), 32'd2);
    repeat (2) pop_small("res small entry", 6, 2);
    chk("res small overflow", 32'(overflow_s), 32'd0);
    chk("res small locked", 32'(locked_s), 32'd1);
    enable_s = 1'b0;

    // duty change 8/2 -> 8/6
    repeat (3) per(8, 2);
    repeat (3) per(8, 6);
    chk("duty count", 32'(q_big.size()), 32'd6);
    pop_big("duty boundary", 6, 2);
    repeat (3) pop_big("duty low", 8, 2);
    repeat (2) pop_big("duty high", 8, 6);

    // enable dropped for three cycles inside a 12/4 period
    repeat (2) per(12, 4);
    pulse_in = 1'b1;
    cycles(4);
    pulse_in = 1'b0;
    cycles(2);
    enable = 1'b0;
    tick();
    chk("dis locked", 32'(locked_b), 32'd0);
    chk("dis valid", 32'(valid_b), 32'd0);
    cycles(2);
    enable = 1'b1;
    cycles(3);
    chk("reen period", 32'(period_b), 32'd12);
    chk("reen high", 32'(high_b), 32'd4);
    per(10, 3);
    chk("reen1 period", 32'(period_b), 32'd12);
    chk("reen1 locked", 32'(locked_b), 32'd0);
    per(10, 3);
    chk("reen2 period", 32'(period_b), 32'd10);
    chk("reen2 high", 32'(high_b), 32'd3);
    chk("reen2 locked", 32'(locked_b), 32'd1);
    chk("en count", 32'(q_big.size()), 32'd4);
    pop_big("en boundary", 8, 6);
    repeat (2) pop_big("en pre", 12, 4);
    pop_big("en post", 10, 3);

    // asynchronous reset between clock edges mid-measurement
    repeat (2) per(10, 5);
    chk("pre_rst count", 32'(q_big.size()), 32'd2);
    pop_big("pre_rst a", 10, 3);
    pop_big("pre_rst b", 10, 5);
    pulse_in = 1'b1;
    cycles(2);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    #1 reset = 1'b1;
    pulse_in = 1'b0;
    cycles(8);
    chk("post_rst count", 32'(q_big.size()), 32'd0);
    chk("post_rst locked", 32'(locked_b), 32'd0);
    repeat (3) per(10, 5);
    chk("relock count", 32'(q_big.size()), 32'd2);
    repeat (2) pop_big("relock entry", 10, 5);
    chk("relock locked", 32'(locked_b), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
